// File: rtl/f_pc_unit.sv
// Fetch-stage program counter: resolves the next fetch address from the D-stage
// control transfer (delay-slot semantics), exception entry, eret and stall hold.
module f_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic [3:0]  NPCOp,
    input  logic [31:0] D_pc,
    input  logic [25:0] imm26,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic [31:0] EPC,
    output logic [31:0] F_pc,
    output logic [31:0] npc,
    output logic        D_taken,
    output logic        F_bd,
    output logic        F_adel,
    output logic        flush_F
);

    localparam logic [3:0] OP_SEQ  = 4'd0;
    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_J    = 4'd2;
    localparam logic [3:0] OP_JR   = 4'd3;
    localparam logic [3:0] OP_BNE  = 4'd4;
    localparam logic [3:0] OP_BLEZ = 4'd5;
    localparam logic [3:0] OP_BGTZ = 4'd6;
    localparam logic [3:0] OP_BLTZ = 4'd7;
    localparam logic [3:0] OP_BGEZ = 4'd8;
    localparam logic [3:0] OP_ERET = 4'd9;

    logic [31:0] f_pc_reg;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        taken;
    logic        rs_neg;
    logic        rs_zero;

    assign pc_plus4  = f_pc_reg + 32'd4;
    assign br_target = D_pc + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign j_target  = {D_pc[31:28], imm26, 2'b00};
    assign rs_neg    = RD1[31];
    assign rs_zero   = (RD1 == 32'd0);

    // Branch conditions only decide taken; the target is common to all branches.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        case (NPCOp)
            OP_BEQ: begin
                taken  = (RD1 == RD2);
                target = br_target;
            end
            OP_BNE: begin
                taken  = (RD1 != RD2);
                target = br_target;
            end
            OP_BLEZ: begin
                taken  = rs_neg | rs_zero;
                target = br_target;
            end
            OP_BGTZ: begin
                taken  = ~rs_neg & ~rs_zero;
                target = br_target;
            end
            OP_BLTZ: begin
                taken  = rs_neg;
                target = br_target;
            end
            OP_BGEZ: begin
                taken  = ~rs_neg;
                target = br_target;
            end
            OP_J: begin
                taken  = 1'b1;
                target = j_target;
            end
            OP_JR: begin
                taken  = 1'b1;
                target = RD1;
            end
            OP_ERET: begin
                taken  = 1'b1;
                target = EPC;
            end
            default: begin
                taken  = 1'b0;
                target = pc_plus4;
            end
        endcase
    end

    assign npc     = taken ? target : pc_plus4;
    assign D_taken = taken;
    // eret has no delay slot, so it is excluded from the delay-slot range.
    assign F_bd    = (NPCOp >= OP_BEQ) && (NPCOp <= OP_BGEZ);
    assign flush_F = req | ((NPCOp == OP_ERET) & ~stall);
    assign F_adel  = (f_pc_reg[1:0] != 2'b00) || (f_pc_reg < TEXT_LO) || (f_pc_reg > TEXT_HI);
    assign F_pc    = f_pc_reg;

    // Exception entry overrides a stall; the stalled F instruction is killed anyway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_reg <= RESET_PC;
        end else if (req) begin
            f_pc_reg <= EXC_VEC;
        end else if (!stall) begin
            f_pc_reg <= npc;
        end
    end

    // Keeps OP_SEQ referenced as the documented sequential encoding.
    logic unused_seq;
    assign unused_seq = (NPCOp == OP_SEQ);

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_f_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  NPCOp = 4'd0;
    logic [31:0] D_pc = 32'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] RD1 = 32'd0;
    logic [31:0] RD2 = 32'd0;
    logic [31:0] EPC = 32'd0;
    logic [31:0] F_pc;
    logic [31:0] npc;
    logic        D_taken;
    logic        F_bd;
    logic        F_adel;
    logic        flush_F;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_fpc = RESET_PC;

    always #5 clk = ~clk;

    f_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .NPCOp(NPCOp),
        .D_pc(D_pc), .imm26(imm26), .RD1(RD1), .RD2(RD2), .EPC(EPC),
        .F_pc(F_pc), .npc(npc), .D_taken(D_taken), .F_bd(F_bd),
        .F_adel(F_adel), .flush_F(flush_F)
    );

    // Reference model computed straight from the control-transfer rules.
    function automatic void model(
        input  logic [3:0]  op,
        input  logic [31:0] dpc, input logic [25:0] imm,
        input  logic [31:0] a, input logic [31:0] b, input logic [31:0] epc,
        input  logic [31:0] fpc, input logic stl, input logic rq,
        output logic [31:0] n, output logic tk, output logic bd,
        output logic fl, output logic ad);
        int signed sa;
        int signed off;
        logic [31:0] tgt;
        sa  = a;
        off = $signed(imm[15:0]);
        tk  = 1'b0;
        tgt = fpc + 32'd4;
        if (op >= 4'd1 && op <= 4'd8) tgt = dpc + 32'd4 + 32'(off * 4);
        case (op)
            4'd1: tk = (a == b);
            4'd4: tk = (a != b);
            4'd5: tk = (sa <= 0);
            4'd6: tk = (sa > 0);
            4'd7: tk = (sa < 0);
            4'd8: tk = (sa >= 0);
            4'd2: begin tk = 1'b1; tgt = (dpc & 32'hf000_0000) | (32'(imm) << 2); end
            4'd3: begin tk = 1'b1; tgt = a; end
            4'd9: begin tk = 1'b1; tgt = epc; end
            default: tk = 1'b0;
        endcase
        n  = tk ? tgt : fpc + 32'd4;
        bd = (op >= 4'd1) && (op <= 4'd8);
        fl = rq || (op == 4'd9 && !stl);
        ad = (fpc % 4 != 0) || (fpc < TEXT_LO) || (fpc > TEXT_HI);
    endfunction

    // Advances one clock and updates the expected PC; no comparisons here.
    task automatic tick();
        logic [31:0] n;
        logic tk, bd, fl, ad;
        model(NPCOp, D_pc, imm26, RD1, RD2, EPC, m_fpc, stall, req, n, tk, bd, fl, ad);
        @(posedge clk);
        if (reset) m_fpc = RESET_PC;
        else if (req) m_fpc = EXC_VEC;
        else if (!stall) m_fpc = n;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (F_pc !== 32'h3000) begin errors++; $display("FAIL reset_fpc: got %h expected %h", F_pc, 32'h3000); end
        reset = 1'b0;
        #1;
        checks++; if (npc !== 32'h3004) begin errors++; $display("FAIL reset_npc: got %h expected %h", npc, 32'h3004); end
        checks++; if ({D_taken, F_bd, F_adel, flush_F} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {D_taken, F_bd, F_adel, flush_F}); end
        tick();
        checks++; if (F_pc !== 32'h3004) begin errors++; $display("FAIL step1: got %h expected %h", F_pc, 32'h3004); end
        tick();
        checks++; if (F_pc !== 32'h3008) begin errors++; $display("FAIL step2: got %h expected %h", F_pc, 32'h3008); end
        @(posedge clk); #2 reset = 1'b1; #1;
        checks++; if (F_pc !== 32'h3000) begin errors++; $display("FAIL async_reset: got %h expected %h", F_pc, 32'h3000); end
        m_fpc = RESET_PC;
        @(negedge clk);
        stall = 1'b1;
        reset = 1'b0;
        tick(); tick();
        checks++; if (F_pc !== 32'h3000) begin errors++; $display("FAIL reset_stall: got %h expected %h", F_pc, 32'h3000); end
        stall = 1'b0;
        tick();
        checks++; if (F_pc !== 32'h3004) begin errors++; $display("FAIL reset_unstall: got %h expected %h", F_pc, 32'h3004); end
    endtask

    task automatic test_beq_stall();
        logic [31:0] held;
        NPCOp = 4'd1; D_pc = 32'h3010; imm26 = 26'h000fffe; RD1 = 32'd5; RD2 = 32'd5;
        #1;
        checks++; if (npc !== 32'h300c) begin errors++; $display("FAIL beq_npc: got %h expected %h", npc, 32'h300c); end
        checks++; if ({D_taken, F_bd} !== 2'b11) begin errors++; $display("FAIL beq_flags: got %b expected 11", {D_taken, F_bd}); end
        RD2 = 32'd6;
        #1;
        checks++; if (npc !== m_fpc + 32'd4) begin errors++; $display("FAIL beq_nt_npc: got %h expected %h", npc, m_fpc + 32'd4); end
        checks++; if ({D_taken, F_bd} !== 2'b01) begin errors++; $display("FAIL beq_nt_flags: got %b expected 01", {D_taken, F_bd}); end
        RD2 = 32'd5;
        stall = 1'b1;
        held = F_pc;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (F_pc !== held) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, F_pc, held); end
        end
        stall = 1'b0;
        tick();
        checks++; if (F_pc !== 32'h300c) begin errors++; $display("FAIL stall_release: got %h expected %h", F_pc, 32'h300c); end
    endtask

    task automatic test_cond_branches();
        logic [3:0]  ops [4] = '{4'd7, 4'd6, 4'd5, 4'd8};
        logic [31:0] rs  [4] = '{32'h8000_0000, 32'd0, 32'd0, 32'd0};
        logic        exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        D_pc = 32'h3100; imm26 = 26'h0000010; RD2 = 32'd0;
        for (int i = 0; i < 4; i++) begin
            NPCOp = ops[i]; RD1 = rs[i];
            #1;
            checks++; if (D_taken !== exp[i]) begin errors++; $display("FAIL cond_op%0d: got %b expected %b", ops[i], D_taken, exp[i]); end
        end
    endtask

    task automatic test_jumps();
        NPCOp = 4'd2; D_pc = 32'h3020; imm26 = 26'h0000c40;
        #1;
        checks++; if (npc !== 32'h3100) begin errors++; $display("FAIL jal_npc: got %h expected %h", npc, 32'h3100); end
        tick();
        NPCOp = 4'd3; RD1 = 32'h3002;
        tick();
        NPCOp = 4'd0;
        #1;
        checks++; if (F_pc !== 32'h3002) begin errors++; $display("FAIL jr_fpc: got %h expected %h", F_pc, 32'h3002); end
        checks++; if (F_adel !== 1'b1) begin errors++; $display("FAIL jr_adel: got %b expected 1", F_adel); end
        NPCOp = 4'd3; RD1 = 32'hffff_fffc;
        tick();
        NPCOp = 4'd0;
        #1;
        checks++; if (npc !== 32'h0) begin errors++; $display("FAIL wrap_npc: got %h expected 0", npc); end
        checks++; if (F_adel !== 1'b1) begin errors++; $display("FAIL wrap_adel_hi: got %b expected 1", F_adel); end
        tick();
        checks++; if ({F_pc, F_adel} !== {32'h0, 1'b1}) begin errors++; $display("FAIL wrap_adel_lo: got %h/%b expected 0/1", F_pc, F_adel); end
    endtask

    task automatic test_eret_req();
        NPCOp = 4'd9; EPC = 32'h3040;
        #1;
        checks++; if ({flush_F, D_taken, F_bd} !== 3'b110) begin errors++; $display("FAIL eret_flags: got %b expected 110", {flush_F, D_taken, F_bd}); end
        tick();
        checks++; if (F_pc !== 32'h3040) begin errors++; $display("FAIL eret_fpc: got %h expected %h", F_pc, 32'h3040); end
        stall = 1'b1;
        #1;
        checks++; if (flush_F !== 1'b0) begin errors++; $display("FAIL eret_stall_flush: got %b expected 0", flush_F); end
        stall = 1'b0; req = 1'b1;
        tick();
        checks++; if (F_pc !== 32'h4180) begin errors++; $display("FAIL eret_req: got %h expected %h", F_pc, 32'h4180); end
        req = 1'b0; NPCOp = 4'd0;
        tick();
        stall = 1'b1; req = 1'b1;
        #1;
        checks++; if (flush_F !== 1'b1) begin errors++; $display("FAIL req_flush: got %b expected 1", flush_F); end
        tick();
        checks++; if (F_pc !== 32'h4180) begin errors++; $display("FAIL req_stall: got %h expected %h", F_pc, 32'h4180); end
        reset = 1'b1;
        #1;
        checks++; if (F_pc !== 32'h3000) begin errors++; $display("FAIL req_reset: got %h expected %h", F_pc, 32'h3000); end
        m_fpc = RESET_PC;
        @(negedge clk);
        reset = 1'b0; req = 1'b0; stall = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] n;
        logic tk, bd, fl, ad;
        for (int i = 0; i < 400; i++) begin
            NPCOp = 4'($urandom_range(0, 15));
            D_pc  = TEXT_LO + 32'($urandom_range(0, 32'h1000)) * 4;
            imm26 = 26'($urandom);
            RD1   = ($urandom_range(0, 3) == 0) ? 32'd0 :
                    ($urandom_range(0, 1) == 0) ? TEXT_LO + 32'($urandom_range(0, 32'h3fff)) : $urandom;
            RD2   = ($urandom_range(0, 2) == 0) ? RD1 : $urandom;
            EPC   = TEXT_LO + 32'($urandom_range(0, 32'h1000)) * 4;
            stall = ($urandom_range(0, 3) == 0);
            req   = ($urandom_range(0, 15) == 0);
            #1;
            model(NPCOp, D_pc, imm26, RD1, RD2, EPC, m_fpc, stall, req, n, tk, bd, fl, ad);
            checks++; if (F_pc !== m_fpc) begin errors++; $display("FAIL rnd%0d_fpc: got %h expected %h", i, F_pc, m_fpc); end
            checks++; if (npc !== n) begin errors++; $display("FAIL rnd%0d_npc op=%0d: got %h expected %h", i, NPCOp, npc, n); end
            checks++; if ({D_taken, F_bd, flush_F, F_adel} !== {tk, bd, fl, ad}) begin
                errors++; $display("FAIL rnd%0d_flags op=%0d: got %b expected %b", i, NPCOp, {D_taken, F_bd, flush_F, F_adel}, {tk, bd, fl, ad});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_beq_stall();
        test_cond_branches();
        test_jumps();
        test_eret_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
